// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch unit: issues word requests to imem, buffers in-order
// responses with their PCs in a DEPTH-entry prefetch queue, feeds decode.
// Ports: clk, rst_n (async low), fetch_en, redirect_valid/redirect_pc,
//   imem_req_valid/ready/addr, imem_rsp_valid/data,
//   out_valid/ready/pc/instr.
// Optional: IFU_PERF_CNT_EN adds perf_stall_cycles and perf_redirects.
module fetch_prefetch_unit #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 30,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_redirects
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_tag [DEPTH];
  logic [PW-1:0]     r_tag_wp;
  logic [PW-1:0]     r_tag_rp;
  logic [CW-1:0]     r_outst;
  logic [CW-1:0]     r_drop;
  logic [ADDR_W-1:0] r_q_pc [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [PW-1:0]     r_q_wp;
  logic [PW-1:0]     r_q_rp;
  logic [CW-1:0]     r_q_cnt;

  logic              w_req_fire;
  logic              w_rsp_keep;
  logic              w_rsp_drop;
  logic              w_push;
  logic              w_pop;
  logic [CW:0]       w_credit;
  logic [CW-1:0]     w_rsp_dec;
  logic [CW-1:0]     w_drop_redir;
  logic [ADDR_W-1:0] w_rsp_pc;

  assign w_credit = {1'b0, r_q_cnt} + {1'b0, r_outst};

  assign imem_req_valid = (r_state != BOOT) && fetch_en &&
                          !redirect_valid && (w_credit < L_DEPTH);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_keep = imem_rsp_valid && (r_drop == '0);
  assign w_rsp_drop = imem_rsp_valid && (r_drop != '0);
  assign w_rsp_dec  = CW'(imem_rsp_valid);

  // A response in the redirect cycle belongs to the old stream too.
  assign w_drop_redir = r_outst - w_rsp_dec;

  // Tag FIFO empty while a kept response lands means a zero-latency
  // memory is answering the request issued this very cycle.
  assign w_rsp_pc = (r_outst == r_drop) ? r_fetch_pc : r_tag[r_tag_rp];

  assign out_valid = (r_q_cnt != '0) && !redirect_valid;
  assign out_pc    = r_q_pc[r_q_rp];
  assign out_instr = r_q_data[r_q_rp];

  assign w_push = w_rsp_keep && !redirect_valid;
  assign w_pop  = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (redirect_valid && (w_drop_redir != '0))
          w_state_nxt = FLUSH;
      end
      FLUSH: begin
        if (redirect_valid)
          w_state_nxt = (w_drop_redir != '0) ? FLUSH : RUN;
        else if ((r_drop == '0) ||
                 (w_rsp_drop && (r_drop == CW'(1))))
          w_state_nxt = RUN;
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_fetch_pc <= RESET_PC;
      r_tag      <= '{default: '0};
      r_tag_wp   <= '0;
      r_tag_rp   <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
      r_q_pc     <= '{default: '0};
      r_q_data   <= '{default: '0};
      r_q_wp     <= '0;
      r_q_rp     <= '0;
      r_q_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        r_tag_wp   <= '0;
        r_tag_rp   <= '0;
        r_q_wp     <= '0;
        r_q_rp     <= '0;
        r_q_cnt    <= '0;
        r_outst    <= w_drop_redir;
        r_drop     <= w_drop_redir;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc       <= r_fetch_pc + ADDR_W'(1);
          r_tag[r_tag_wp]  <= r_fetch_pc;
          r_tag_wp         <= r_tag_wp + PW'(1);
        end
        if (w_rsp_keep)
          r_tag_rp <= r_tag_rp + PW'(1);
        if (w_push) begin
          r_q_pc[r_q_wp]   <= w_rsp_pc;
          r_q_data[r_q_wp] <= imem_rsp_data;
          r_q_wp           <= r_q_wp + PW'(1);
        end
        if (w_pop)
          r_q_rp <= r_q_rp + PW'(1);
        r_q_cnt <= r_q_cnt + CW'(w_push) - CW'(w_pop);
        r_outst <= r_outst + CW'(w_req_fire) - w_rsp_dec;
        if (w_rsp_drop)
          r_drop <= r_drop - CW'(1);
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_redir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_redir <= '0;
    end else begin
      if (out_valid && !out_ready && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
      if (redirect_valid && (r_perf_redir != '1))
        r_perf_redir <= r_perf_redir + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_redirects    = r_perf_redir;
`endif

  a_rsp_expected: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> ((r_outst != '0) || w_req_fire)
  );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed testbench for fetch_prefetch_unit.
// Fixed-latency in-order memory model; per-scenario tasks.
module tb_fetch_prefetch_unit;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam logic [AW-1:0] RPC = 30'h10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_instr;
`ifdef IFU_PERF_CNT_EN
  logic [31:0]   perf_stall_cycles;
  logic [31:0]   perf_redirects;
`endif

  int total = 0;
  int bad = 0;
  int lat = 0;

  logic          pv [4];
  logic [AW-1:0] pa [4];
  logic          rsp_v;
  logic [AW-1:0] rsp_a;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(4), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_redirects(perf_redirects)
`endif
  );

  function automatic logic [DW-1:0] mem_img(input logic [AW-1:0] a);
    return 32'hC0DE0000 ^ {2'b00, a};
  endfunction

  assign imem_req_ready = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
      end
    end else begin
      pv[0] <= imem_req_valid && imem_req_ready;
      pa[0] <= imem_req_addr;
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  always_comb begin
    rsp_v = 1'b0;
    rsp_a = imem_req_addr;
    case (lat)
      0: begin
        rsp_v = imem_req_valid && imem_req_ready;
        rsp_a = imem_req_addr;
      end
      1: begin rsp_v = pv[0]; rsp_a = pa[0]; end
      2: begin rsp_v = pv[1]; rsp_a = pa[1]; end
      3: begin rsp_v = pv[2]; rsp_a = pa[2]; end
      default: begin rsp_v = pv[3]; rsp_a = pa[3]; end
    endcase
  end

  assign imem_rsp_valid = rsp_v;
  assign imem_rsp_data  = mem_img(rsp_a);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0;
    lat = l;
    fetch_en = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    lat = 0;
    fetch_en = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL rst_req_valid got=%b want=0", imem_req_valid);
    end
    total++;
    if (out_pc !== '0) begin
      bad++; $display("FAIL rst_out_pc got=%h want=0", out_pc);
    end
    total++;
    if (out_instr !== '0) begin
      bad++; $display("FAIL rst_out_instr got=%h want=0", out_instr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    smp();
    total++;
    if (imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL boot_req_valid got=%b want=0", imem_req_valid);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL boot_out_valid got=%b want=0", out_valid);
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] e;
    do_reset(0);
    cyc(); smp();
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
      bad++;
      $display("FAIL stream_req got v=%b a=%h want v=1 a=%h",
               imem_req_valid, imem_req_addr, RPC);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL stream_early got=%b want=0", out_valid);
    end
    cyc(); smp();
    for (int k = 0; k < 6; k++) begin
      e = RPC + AW'(k);
      total++;
      if (out_valid !== 1'b1 || out_pc !== e || out_instr !== mem_img(e)) begin
        bad++;
        $display("FAIL stream_%0d got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                 k, out_valid, out_pc, out_instr, e, mem_img(e));
      end
      cyc(); smp();
    end
  endtask

  task automatic test_stall();
    int fires;
    int stalls;
    int pc_bad;
    do_reset(0);
    out_ready = 1'b0;
    fires = 0; stalls = 0; pc_bad = 0;
    for (int n = 0; n < 12; n++) begin
      smp();
      if (imem_req_valid && imem_req_ready) fires++;
      if (out_valid && !out_ready) begin
        stalls++;
        if (out_pc !== RPC) pc_bad++;
      end
      cyc();
    end
    out_ready = 1'b1;
    smp();
    total++;
    if (fires != 4) begin
      bad++; $display("FAIL stall_reqs got=%0d want=4", fires);
    end
    total++;
    if (stalls != 10) begin
      bad++; $display("FAIL stall_cycles got=%0d want=10", stalls);
    end
    total++;
    if (pc_bad != 0) begin
      bad++; $display("FAIL stall_pc_hold got=%0d bad cycles want=0", pc_bad);
    end
    total++;
    if (imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL stall_req_off got=%b want=0", imem_req_valid);
    end
    total++;
    if (out_valid !== 1'b1 || out_pc !== RPC) begin
      bad++;
      $display("FAIL stall_head got v=%b pc=%h want v=1 pc=%h",
               out_valid, out_pc, RPC);
    end
`ifdef IFU_PERF_CNT_EN
    total++;
    if (perf_stall_cycles !== 32'd10) begin
      bad++; $display("FAIL perf_stall got=%0d want=10", perf_stall_cycles);
    end
`endif
    cyc(); smp();
    total++;
    if (out_valid !== 1'b1 || out_pc !== RPC + AW'(1)) begin
      bad++;
      $display("FAIL stall_pop got v=%b pc=%h want v=1 pc=%h",
               out_valid, out_pc, RPC + AW'(1));
    end
  endtask

  task automatic test_flush();
    logic [AW-1:0] e;
    logic [AW-1:0] nxt;
    int found;
    int first;
    int seq_bad;
    int nouts;
    do_reset(3);
    for (int c = 1; c <= 3; c++) begin
      cyc(); smp();
      e = RPC + AW'(c - 1);
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== e) begin
        bad++;
        $display("FAIL flush_issue_%0d got v=%b a=%h want v=1 a=%h",
                 c, imem_req_valid, imem_req_addr, e);
      end
    end
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 30'h40;
    smp();
    total++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_redir got ov=%b rv=%b want 0 0",
               out_valid, imem_req_valid);
    end
    cyc();
    redirect_valid = 1'b0;
    smp();
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 30'h40) begin
      bad++;
      $display("FAIL flush_new_req got v=%b a=%h want v=1 a=40",
               imem_req_valid, imem_req_addr);
    end
    found = 0; first = 0; seq_bad = 0; nouts = 0;
    nxt = 30'h40;
    for (int n = 5; n < 20; n++) begin
      if (out_valid) begin
        if (found == 0) begin
          found = 1;
          first = n;
        end
        if (out_pc !== nxt || out_instr !== mem_img(nxt)) seq_bad++;
        nxt = nxt + AW'(1);
        nouts++;
      end
      cyc(); smp();
    end
    total++;
    if (found == 0 || first != 9) begin
      bad++;
      $display("FAIL flush_latency got found=%0d cycle=%0d want cycle=9",
               found, first);
    end
    total++;
    if (seq_bad != 0 || nouts < 5) begin
      bad++;
      $display("FAIL flush_seq got bad=%0d outs=%0d want bad=0 outs>=5",
               seq_bad, nouts);
    end
`ifdef IFU_PERF_CNT_EN
    total++;
    if (perf_redirects !== 32'd1) begin
      bad++; $display("FAIL perf_redir got=%0d want=1", perf_redirects);
    end
`endif
  endtask

  task automatic test_collide();
    repeat (0) cyc();
    do_reset(1);
    repeat (4) cyc();
    smp();
    total++;
    if (out_valid !== 1'b1 || out_pc !== RPC + AW'(1)) begin
      bad++;
      $display("FAIL collide_pre got v=%b pc=%h want v=1 pc=%h",
               out_valid, out_pc, RPC + AW'(1));
    end
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 30'h80;
    smp();
    total++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL collide_redir got ov=%b rv=%b want 0 0",
               out_valid, imem_req_valid);
    end
    cyc();
    redirect_valid = 1'b0;
    smp();
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 30'h80 ||
        out_valid !== 1'b0) begin
      bad++;
      $display("FAIL collide_req got rv=%b a=%h ov=%b want 1 80 0",
               imem_req_valid, imem_req_addr, out_valid);
    end
    cyc(); smp();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL collide_gap got=%b want=0", out_valid);
    end
    cyc(); smp();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 30'h80 ||
        out_instr !== mem_img(30'h80)) begin
      bad++;
      $display("FAIL collide_out got v=%b pc=%h i=%h want v=1 pc=80 i=%h",
               out_valid, out_pc, out_instr, mem_img(30'h80));
    end
  endtask

  task automatic test_wrap();
    do_reset(1);
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 30'h3FFFFFFF;
    smp();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL wrap_redir got=%b want=0", out_valid);
    end
    cyc();
    redirect_valid = 1'b0;
    smp();
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 30'h3FFFFFFF) begin
      bad++;
      $display("FAIL wrap_req_top got v=%b a=%h want v=1 a=3fffffff",
               imem_req_valid, imem_req_addr);
    end
    cyc(); smp();
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 30'h0) begin
      bad++;
      $display("FAIL wrap_req_zero got v=%b a=%h want v=1 a=0",
               imem_req_valid, imem_req_addr);
    end
    cyc(); smp();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 30'h3FFFFFFF) begin
      bad++;
      $display("FAIL wrap_out_top got v=%b pc=%h want v=1 pc=3fffffff",
               out_valid, out_pc);
    end
    cyc(); smp();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 30'h0 ||
        out_instr !== mem_img(30'h0)) begin
      bad++;
      $display("FAIL wrap_out_zero got v=%b pc=%h i=%h want v=1 pc=0 i=%h",
               out_valid, out_pc, out_instr, mem_img(30'h0));
    end
  endtask

  task automatic test_reset_mid();
    int found;
    int first;
    logic [AW-1:0] fpc;
    do_reset(2);
    repeat (4) cyc();
    smp();
    total++;
    if (out_valid !== 1'b1 || out_pc !== RPC) begin
      bad++;
      $display("FAIL rstmid_pre got v=%b pc=%h want v=1 pc=%h",
               out_valid, out_pc, RPC);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_valid got ov=%b rv=%b want 0 0",
               out_valid, imem_req_valid);
    end
    total++;
    if (out_pc !== '0 || out_instr !== '0) begin
      bad++;
      $display("FAIL rstmid_out got pc=%h i=%h want 0 0", out_pc, out_instr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(); smp();
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
      bad++;
      $display("FAIL rstmid_restart got v=%b a=%h want v=1 a=%h",
               imem_req_valid, imem_req_addr, RPC);
    end
    found = 0; first = 0; fpc = '0;
    for (int n = 1; n < 12; n++) begin
      if (out_valid && found == 0) begin
        found = 1;
        first = n;
        fpc = out_pc;
      end
      cyc(); smp();
    end
    total++;
    if (found == 0 || first != 4 || fpc !== RPC) begin
      bad++;
      $display("FAIL rstmid_first got found=%0d cycle=%0d pc=%h want cycle=4 pc=%h",
               found, first, fpc, RPC);
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_collide();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
